// File: rtl/graph_pkg.sv
// Shared definitions for the graph pipeline (decoder, adjacency_map,
// path_counter).
//   node_t               : node index at the default width
//   path_counter_state_t : traversal controller states
//   DEFAULT_*            : default widths/depths reused across blocks
package graph_pkg;

  localparam int DEFAULT_NODE_WIDTH  = 10;
  localparam int DEFAULT_STACK_DEPTH = 256;
  localparam int DEFAULT_COUNT_WIDTH = 48;

  typedef logic [DEFAULT_NODE_WIDTH-1:0] node_t;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CHECK,
    QUERY,
    COLLECT,
    DONE,
    ERROR
  } path_counter_state_t;

endpackage

// File: rtl/lifo_stack.sv
// LIFO stack with a combinational read of the top entry.
//   clk, rst      : clock, synchronous active-high reset (empties the stack)
//   clear         : discard the contents this cycle; a simultaneous push
//                   lands in entry 0
//   push/push_data: write a new top entry (ignored when full)
//   pop           : drop the top entry (ignored when empty or pushing)
//   top_data      : current top entry, valid while !empty
//   full, empty   : occupancy flags
//   count         : number of entries held
// DEPTH must be a power of two and at least 2.
module lifo_stack import graph_pkg::*; #(
  parameter int WIDTH = DEFAULT_NODE_WIDTH,
  parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       top_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
  localparam logic [AW:0]   ONE        = 1;
  localparam logic [AW-1:0] ONE_ADDR   = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp_reg;
  logic [AW:0]      base;
  logic [AW-1:0]    top_addr;
  logic             do_push;
  logic             do_pop;

  // A clear rebases the pointer to zero so a restart can push its root
  // even when the previous traversal aborted with the stack full.
  assign base     = clear ? '0 : sp_reg;
  assign do_push  = push && (base != FULL_LEVEL);
  assign do_pop   = pop && !push && !clear && (sp_reg != '0);
  assign top_addr = sp_reg[AW-1:0] - ONE_ADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg <= '0;
    end else if (do_push) begin
      sp_reg <= base + ONE;
    end else if (do_pop) begin
      sp_reg <= sp_reg - ONE;
    end else begin
      sp_reg <= base;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[base[AW-1:0]] <= push_data;
    end
  end

  assign top_data = mem[top_addr];
  assign full     = (sp_reg == FULL_LEVEL);
  assign empty    = (sp_reg == '0);
  assign count    = sp_reg;

endmodule

// File: rtl/path_counter.sv
// Depth-first path counter over the DAG held in adjacency_map.
// Pops a node from an explicit stack, counts it if it is the target,
// otherwise queries its successors and pushes each reply beat.
//   clk, rst                     : clock, synchronous active-high reset
//   start/start_node/target_node : launch a traversal (IDLE/DONE/ERROR)
//   query_ready/valid/data       : node expansion request to the map
//   reply_valid/last/data/no_edges_found, reply_ready : successor beats
//   busy, done, error            : traversal status (levels)
//   path_count, count_saturated  : result and sticky clip flag
module path_counter import graph_pkg::*; #(
  parameter int NODE_WIDTH  = DEFAULT_NODE_WIDTH,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NODE_WIDTH-1:0]  start_node,
  input  logic [NODE_WIDTH-1:0]  target_node,
  input  logic                   query_ready,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  input  logic                   reply_valid,
  input  logic                   reply_last,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  input  logic                   reply_no_edges_found,
  output logic                   reply_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] path_count,
  output logic                   count_saturated
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

  path_counter_state_t state_reg, state_next;

  logic [NODE_WIDTH-1:0]  cur_reg;
  logic [NODE_WIDTH-1:0]  target_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   sat_reg;

  logic                   restart;
  logic                   stack_push;
  logic [NODE_WIDTH-1:0]  stack_push_data;
  logic                   stack_pop;
  logic [NODE_WIDTH-1:0]  stack_top;
  logic                   stack_full;
  logic                   stack_empty;
  logic [SP_W-1:0]        stack_count;
  logic                   is_target;
  logic                   beat_wants_push;

  assign restart   = start && ((state_reg == IDLE) || (state_reg == DONE) ||
                               (state_reg == ERROR));
  assign is_target = (cur_reg == target_reg);
  assign beat_wants_push = (state_reg == COLLECT) && reply_valid &&
                           !reply_no_edges_found;

  // Overflowing beats are dropped: the push is suppressed when full.
  assign stack_push      = restart || (beat_wants_push && !stack_full);
  assign stack_push_data = restart ? start_node : reply_data;
  assign stack_pop       = (state_reg == POP) && (stack_count != '0);

  lifo_stack #(
    .WIDTH (NODE_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .push      (stack_push),
    .push_data (stack_push_data),
    .pop       (stack_pop),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .count     (stack_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) state_next = POP;
      end
      POP: begin
        state_next = stack_empty ? DONE : CHECK;
      end
      CHECK: begin
        // The target is counted but never expanded.
        state_next = is_target ? POP : QUERY;
      end
      QUERY: begin
        if (query_ready) state_next = COLLECT;
      end
      COLLECT: begin
        if (reply_valid) begin
          // A no-edges reply is always a single beat, whatever reply_last says.
          if (reply_no_edges_found) begin
            state_next = POP;
          end else if (stack_full) begin
            state_next = ERROR;
          end else if (reply_last) begin
            state_next = POP;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs; query_valid is gated by state because the map latches
  // its index on any query_valid.
  always_comb begin
    query_valid = (state_reg == QUERY) && query_ready;
    query_data  = cur_reg;
    reply_ready = (state_reg == COLLECT);
    busy        = (state_reg == POP) || (state_reg == CHECK) ||
                  (state_reg == QUERY) || (state_reg == COLLECT);
    done        = (state_reg == DONE);
    error       = (state_reg == ERROR);
  end

  // Datapath: current node, latched target, saturating path counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_reg    <= '0;
      target_reg <= '0;
      count_reg  <= '0;
      sat_reg    <= 1'b0;
    end else begin
      if (restart) begin
        target_reg <= target_node;
        count_reg  <= '0;
        sat_reg    <= 1'b0;
      end
      if ((state_reg == POP) && !stack_empty) begin
        cur_reg <= stack_top;
      end
      if ((state_reg == CHECK) && is_target) begin
        if (&count_reg) begin
          sat_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + COUNT_ONE;
        end
      end
    end
  end

  assign path_count      = count_reg;
  assign count_saturated = sat_reg;

endmodule

// File: tb/tb_path_counter.sv
// Scoreboard bench for path_counter with a behavioural adjacency map.
// Expected queries and results are queued when each traversal is
// launched; monitor processes pop and compare as the DUT presents them.
module tb_path_counter;
  import graph_pkg::*;

  localparam int NW = 10;
  localparam int CW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] start_node;
  logic [NW-1:0] target_node;
  logic          query_ready;
  logic          query_valid;
  logic [NW-1:0] query_data;
  logic          reply_valid;
  logic          reply_last;
  logic [NW-1:0] reply_data;
  logic          reply_no_edges_found;
  logic          reply_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] path_count;
  logic          count_saturated;

  always #5 clk = ~clk;

  // Depth 2 is enough for chain/diamond and makes the overflow case small.
  path_counter #(
    .NODE_WIDTH  (NW),
    .STACK_DEPTH (2),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .start_node           (start_node),
    .target_node          (target_node),
    .query_ready          (query_ready),
    .query_valid          (query_valid),
    .query_data           (query_data),
    .reply_valid          (reply_valid),
    .reply_last           (reply_last),
    .reply_data           (reply_data),
    .reply_no_edges_found (reply_no_edges_found),
    .reply_ready          (reply_ready),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .path_count           (path_count),
    .count_saturated      (count_saturated)
  );

  typedef struct {
    logic [CW-1:0] count;
    logic          done;
    logic          error;
  } res_t;

  res_t          exp_res [$];
  logic [NW-1:0] exp_qry [$];
  int            n_cmp = 0;
  int            n_err = 0;

  int            succ_n [16];
  logic [NW-1:0] succ   [16][4];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_graph();
    for (int i = 0; i < 16; i++) succ_n[i] = 0;
  endtask

  task automatic set_edges(input int n, input int cnt, input int a,
                           input int b, input int c);
    succ_n[n]  = cnt;
    succ[n][0] = NW'(a);
    succ[n][1] = NW'(b);
    succ[n][2] = NW'(c);
  endtask

  task automatic pulse_start(input int s, input int t);
    @(negedge clk);
    start       = 1'b1;
    start_node  = NW'(s);
    target_node = NW'(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int cyc;
    cyc = 0;
    while (exp_res.size() != 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    if (exp_res.size() != 0) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      exp_res.delete();
    end
    check({name, "_queries_left"}, 64'(exp_qry.size()), 64'd0);
    exp_qry.delete();
  endtask

  // Adjacency map model: one beat every two cycles; a node without
  // successors answers with a single no-edges beat whose reply_last is 0.
  initial begin
    int node;
    int nb;
    reply_valid          = 1'b0;
    reply_last           = 1'b0;
    reply_data           = '0;
    reply_no_edges_found = 1'b0;
    forever begin
      @(negedge clk);
      if (query_valid === 1'b1 && rst === 1'b0) begin
        node = int'(query_data[3:0]);
        nb   = succ_n[node];
        @(posedge clk);
        if (nb == 0) begin
          #1;
          reply_valid          = 1'b1;
          reply_no_edges_found = 1'b1;
          reply_last           = 1'b0;
          reply_data           = '1;
          @(posedge clk);
          #1;
          reply_valid          = 1'b0;
          reply_no_edges_found = 1'b0;
        end else begin
          for (int k = 0; k < nb; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            reply_valid = 1'b1;
            reply_data  = succ[node][k];
            reply_last  = (k == nb - 1);
            @(posedge clk);
            #1;
            reply_valid = 1'b0;
            reply_last  = 1'b0;
          end
        end
      end
    end
  end

  // Query monitor
  initial begin
    logic [NW-1:0] e;
    forever begin
      @(negedge clk);
      if (query_valid === 1'b1) begin
        if (exp_qry.size() == 0) begin
          check("unexpected_query", 64'(query_data), 64'h3ff);
        end else begin
          e = exp_qry.pop_front();
          check("query_node", 64'(query_data), 64'(e));
        end
      end
    end
  end

  // Result monitor: fires on the rising edge of done|error
  initial begin
    logic fin_prev;
    logic fin_now;
    res_t r;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      fin_now = (done === 1'b1) || (error === 1'b1);
      if (fin_now && !fin_prev) begin
        if (exp_res.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          r = exp_res.pop_front();
          check("path_count", 64'(path_count), 64'(r.count));
          check("done", 64'(done), 64'(r.done));
          check("error", 64'(error), 64'(r.error));
          check("busy_at_end", 64'(busy), 64'd0);
          check("saturated", 64'(count_saturated), 64'd0);
          $display("result: count=%0d done=%0b error=%0b", path_count, done, error);
        end
      end
      fin_prev = fin_now;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst         = 1'b1;
    start       = 1'b0;
    start_node  = '0;
    target_node = '0;
    query_ready = 1'b1;
    clear_graph();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_query_valid", 64'(query_valid), 64'd0);
    check("rst_reply_ready", 64'(reply_ready), 64'd0);
    check("rst_path_count", 64'(path_count), 64'd0);
    rst = 1'b0;

    // Chain 0->1->2
    clear_graph();
    set_edges(0, 1, 1, 0, 0);
    set_edges(1, 1, 2, 0, 0);
    exp_qry.push_back(NW'(0));
    exp_qry.push_back(NW'(1));
    exp_res.push_back('{48'd1, 1'b1, 1'b0});
    pulse_start(0, 2);
    wait_result("chain");

    // Diamond 0->{1,2}, 1->3, 2->3, 3->4; LIFO expands 2 before 1
    clear_graph();
    set_edges(0, 2, 1, 2, 0);
    set_edges(1, 1, 3, 0, 0);
    set_edges(2, 1, 3, 0, 0);
    set_edges(3, 1, 4, 0, 0);
    exp_qry.push_back(NW'(0));
    exp_qry.push_back(NW'(2));
    exp_qry.push_back(NW'(3));
    exp_qry.push_back(NW'(1));
    exp_qry.push_back(NW'(3));
    exp_res.push_back('{48'd2, 1'b1, 1'b0});
    pulse_start(0, 4);
    wait_result("diamond");

    // Dead end: 0->1, node 1 has no edges
    clear_graph();
    set_edges(0, 1, 1, 0, 0);
    exp_qry.push_back(NW'(0));
    exp_qry.push_back(NW'(1));
    exp_res.push_back('{48'd0, 1'b1, 1'b0});
    pulse_start(0, 7);
    wait_result("dead_end");

    // Overflow: depth 2, 0->{1,2,3}
    clear_graph();
    set_edges(0, 3, 1, 2, 3);
    exp_qry.push_back(NW'(0));
    exp_res.push_back('{48'd0, 1'b0, 1'b1});
    pulse_start(0, 9);
    wait_result("overflow");

    // Start equals target, launched from ERROR: done 4 cycles after start
    exp_res.push_back('{48'd1, 1'b1, 1'b0});
    @(negedge clk);
    start       = 1'b1;
    start_node  = NW'(5);
    target_node = NW'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("same_busy_after_start", 64'(busy), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("same_done_early", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    check("same_done_latency", 64'(done), 64'd1);
    wait_result("start_eq_target");

    // Reset while in COLLECT, then rerun the chain
    clear_graph();
    set_edges(0, 1, 1, 0, 0);
    set_edges(1, 1, 2, 0, 0);
    exp_qry.push_back(NW'(0));
    pulse_start(0, 2);
    cyc = 0;
    while (reply_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_collect", 64'(reply_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    check("mid_rst_reply_ready", 64'(reply_ready), 64'd0);
    check("mid_rst_query_valid", 64'(query_valid), 64'd0);
    check("mid_rst_path_count", 64'(path_count), 64'd0);
    check("mid_rst_saturated", 64'(count_saturated), 64'd0);
    check("mid_rst_queries_left", 64'(exp_qry.size()), 64'd0);
    repeat (3) @(negedge clk);
    exp_qry.push_back(NW'(0));
    exp_qry.push_back(NW'(1));
    exp_res.push_back('{48'd1, 1'b1, 1'b0});
    pulse_start(0, 2);
    wait_result("chain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
